// File: rtl/shift_rows_stream.sv
// shift_rows_stream
//
// Pipelined Rijndael ShiftRows stage for the AES round datapath. One state
// block per cycle enters over a valid/ready handshake, is permuted
// combinationally (forward, or inverse when compiled in), and is held in a
// registered output stage backed by one skid register. This lets the stage
// sustain full throughput while in_ready stays a pure register output.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds valid and data until that edge. out_data
// does not change while out_valid=1 and out_ready=0.
//
// Parameters:
//   NB          columns per state (4, 6 or 8); W = 32*NB
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   in_valid    in_data / in_inv carry a block
//   in_ready    stage accepts a block this cycle
//   in_data     W-bit state, column-major; byte (r,c) at [W-1-8*(4c+r) -: 8]
//   in_inv      1 = inverse ShiftRows for this block
//   out_valid   out_data holds a transformed block
//   out_ready   downstream accepts out_data this cycle
//   out_data    W-bit transformed state, same byte layout
//
// Build option:
//   SHIFT_ROWS_STREAM_INV_EN  when defined, in_inv selects the inverse
//                             permutation per block. When undefined, only the
//                             forward permutation is built and in_inv is
//                             ignored.

module shift_rows_stream #(
    parameter int NB = 4,
    localparam int W = 32 * NB
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Rijndael row offsets: Nb=4/6 use (0,1,2,3), Nb=8 uses (0,1,3,4).
    function automatic int row_off(input int r);
        if (NB == 8 && r == 2) return 3;
        if (NB == 8 && r == 3) return 4;
        return r;
    endfunction

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_stream: NB must be 4, 6 or 8");
    end

    logic [W-1:0] fwd_data;
    logic [W-1:0] xf_data;

    // Pure wiring: every output byte picks one input byte from the same row.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SRC_F = (c + row_off(r)) % NB;
            assign fwd_data[W-1-8*(4*c+r) -: 8] = in_data[W-1-8*(4*SRC_F+r) -: 8];
        end
    end

`ifdef SHIFT_ROWS_STREAM_INV_EN
    logic [W-1:0] inv_data;

    for (genvar c = 0; c < NB; c++) begin : g_icol
        for (genvar r = 0; r < 4; r++) begin : g_irow
            localparam int SRC_I = (c - row_off(r) + NB) % NB;
            assign inv_data[W-1-8*(4*c+r) -: 8] = in_data[W-1-8*(4*SRC_I+r) -: 8];
        end
    end

    // One 2:1 mux per byte in front of the registers.
    assign xf_data = in_inv ? inv_data : fwd_data;
`else
    logic unused_inv;
    assign unused_inv = in_inv;
    assign xf_data    = fwd_data;
`endif

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         in_fire;
    logic         out_fire;

    // in_ready depends only on the skid register and reset, never on
    // out_ready, so it does not lengthen the downstream ready path.
    assign in_ready = ~skid_valid & ~reset;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (out_fire && skid_valid) begin
            // Skid block advances; in_ready was 0 so no input can arrive.
            out_data   <= skid_data;
            skid_valid <= 1'b0;
        end else if (in_fire) begin
            if (!out_valid || out_ready) begin
                // Output register empty or draining this cycle.
                out_data  <= xf_data;
                out_valid <= 1'b1;
            end else begin
                skid_data  <= xf_data;
                skid_valid <= 1'b1;
            end
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
module tb_shift_rows_stream;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_inv, out_valid, out_ready;
    logic [127:0] in_data, out_data;
    logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8;
    logic [255:0] in_data8, out_data8;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    shift_rows_stream #(.NB(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    shift_rows_stream #(.NB(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_inv(in_inv8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference ShiftRows for Nb=4: byte-array view, row r rotated left by r.
    function automatic logic [127:0] sr_model(input logic [127:0] d, input logic inv);
        logic [7:0]   b[16];
        logic [127:0] o;
        int           sc;
        logic         use_inv;
`ifdef SHIFT_ROWS_STREAM_INV_EN
        use_inv = inv;
`else
        use_inv = 1'b0;
        if (inv) use_inv = 1'b0;
`endif
        for (int k = 0; k < 16; k++) b[k] = d[127-8*k -: 8];
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                sc = use_inv ? (c + 4 - r) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = b[4*sc+r];
            end
        return o;
    endfunction

    // Called with inputs already driven after a falling edge. Observes the
    // handshake mid-cycle, updates the scoreboard, returns at the next
    // falling edge (after the active edge has taken effect).
    task automatic step();
        logic in_fire, out_fire;
        #1;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (out_fire) begin
            n_out++;
            check("sb_has_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("sb_data", out_data, exp_q.pop_front());
        end
        if (in_fire) exp_q.push_back(sr_model(in_data, in_inv));
        @(negedge clk);
    endtask

    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT_FWD = 128'hd4b411e5e0419830b8275dae1ebf52f1;
    localparam logic [255:0] NB8_IN  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] NB8_OUT =
        256'h00050e13040912170_80d161b0c111a1f10151e0314190207181d060b1c010a0f;

    logic [127:0] blk[4];
    logic [127:0] inv_exp;
    int           idx;
    int           out_base;
    logic         exp_rdy[10];
    logic         exp_ov[10];

    initial begin
        reset = 1'b1;
        in_valid = 0; in_data = '0; in_inv = 0; out_ready = 0;
        in_valid8 = 0; in_data8 = '0; in_inv8 = 0; out_ready8 = 0;
        @(negedge clk);
        step();
        check("rst_in_ready_low", in_ready, 0);
        step();

        // Reset values
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid8", out_valid8, 0);
        @(negedge clk);

        // FIPS-197 forward vector, one-cycle latency
        in_valid = 1; in_data = FIPS_IN; in_inv = 0; out_ready = 1;
        step();
        in_valid = 0;
        check("fips_fwd_valid", out_valid, 1);
        check("fips_fwd_data", out_data, FIPS_OUT);
        step();
        check("fips_fwd_drained", out_valid, 0);

        // Inverse vector (forward result when inverse is not built)
`ifdef SHIFT_ROWS_STREAM_INV_EN
        inv_exp = FIPS_IN;
`else
        inv_exp = FIPS_OUT_FWD;
`endif
        in_valid = 1; in_data = FIPS_OUT; in_inv = 1;
        step();
        in_valid = 0; in_inv = 0;
        check("inv_valid", out_valid, 1);
        check("inv_data", out_data, inv_exp);
        step();

        // NB=8: row offsets (0,1,3,4)
        in_valid8 = 1; in_data8 = NB8_IN; out_ready8 = 1;
        step();
        in_valid8 = 0;
        check("nb8_valid", out_valid8, 1);
        check("nb8_first_col", out_data8[255:224], 32'h00050e13);
        check("nb8_last_col", out_data8[31:0], 32'h1c010a0f);
        check("nb8_data", out_data8, NB8_OUT);
        step();
        check("nb8_drained", out_valid8, 0);

        // Backpressure: out_ready low for 5 cycles, blocks A..D
        blk[0] = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
        blk[1] = 128'hb0b1b2b3b4b5b6b7b8b9babbbcbdbebf;
        blk[2] = 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf;
        blk[3] = 128'hd0d1d2d3d4d5d6d7d8d9dadbdcdddedf;
        exp_rdy = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
        exp_ov  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        idx = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (idx < 4);
            in_data   = blk[idx % 4];
            #1;
            check($sformatf("bp_in_ready_c%0d", cyc), in_ready, exp_rdy[cyc]);
            check($sformatf("bp_out_valid_c%0d", cyc), out_valid, exp_ov[cyc]);
            if (in_valid && in_ready) idx++;
            step();
        end
        in_valid = 0;
        check("bp_all_accepted", idx, 4);
        check("bp_queue_empty", exp_q.size(), 0);

        // Reset mid-stream with two blocks held
        out_ready = 0;
        in_valid = 1; in_data = blk[0];
        step();
        in_data = blk[1];
        step();
        check("mid_in_ready_full", in_ready, 0);
        reset = 1; in_data = blk[2];
        step();
        reset = 0; in_valid = 0;
        exp_q.delete();
        #1;
        check("mid_out_valid", out_valid, 0);
        check("mid_out_data", out_data, 0);
        check("mid_in_ready", in_ready, 1);
        @(negedge clk);
        out_ready = 1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            check("mid_no_ghost", out_valid, 0);
            step();
        end

        // Full throughput with counting data
        out_base = n_out;
        out_ready = 1;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1;
            for (int j = 0; j < 16; j++) in_data[127-8*j -: 8] = 8'((16 * k + j) & 8'hff);
            #1;
            check($sformatf("tp_in_ready_%0d", k), in_ready, 1);
            if (k > 0) check($sformatf("tp_out_valid_%0d", k), out_valid, 1);
            step();
        end
        in_valid = 0;
        step();
        check("tp_out_count", n_out - out_base, 16);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
